// File: rtl/clk_freq_meter.sv
// clk_freq_meter: counts rising edges of an asynchronous signal over a gate window.
// Optional no-edge watchdog is enabled by defining CLK_FREQ_METER_LOSS_DETECT_EN.
module clk_freq_meter #(
  parameter int GATE_CYCLES  = 1000,
  parameter int COUNT_W      = 16,
  parameter int MIN_COUNT    = 0,
  parameter int MAX_COUNT    = 65535,
  parameter int CONTINUOUS   = 0,
  parameter int LOSS_TIMEOUT = 1024
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic               meas_in,
  output logic               busy,
  output logic [COUNT_W-1:0] count,
  output logic               count_valid,
  output logic               in_range,
  output logic               loss_of_clock
);

  localparam int GW = $clog2(GATE_CYCLES);
  localparam logic [GW-1:0] GLAST = GW'(GATE_CYCLES - 1);
  localparam longint CMAX = (64'd1 << COUNT_W) - 1;
  localparam logic [COUNT_W-1:0] MINV = COUNT_W'(MIN_COUNT);
  localparam logic [COUNT_W-1:0] MAXV =
    (longint'(MAX_COUNT) >= CMAX) ? {COUNT_W{1'b1}} : COUNT_W'(MAX_COUNT);

  if (GATE_CYCLES < 2 || LOSS_TIMEOUT < 1) begin : g_bad_param
    $error("clk_freq_meter: GATE_CYCLES must be >= 2, LOSS_TIMEOUT >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_MEASURE,
    S_REPORT
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_s1;
  logic                r_s2;
  logic                r_s3;
  logic                w_edge;
  logic [GW-1:0]       r_gate;
  logic [COUNT_W-1:0]  r_ecnt;
  logic [COUNT_W-1:0]  r_count;
  logic                r_valid;
  logic                r_inr;
  logic                w_clr;
  logic                w_cnt_en;
  logic                w_report;
  logic                w_lo_ok;
  logic                w_hi_ok;
  logic                w_in_range;
  logic                w_loss;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= meas_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign w_edge = r_s2 & ~r_s3;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_clr       = 1'b0;
    w_cnt_en    = 1'b0;
    w_report    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start || CONTINUOUS != 0) begin
          w_clr       = 1'b1;
          w_state_nxt = S_MEASURE;
        end
      end
      S_MEASURE: begin
        w_cnt_en = 1'b1;
        if (r_gate == GLAST) w_state_nxt = S_REPORT;
      end
      S_REPORT: begin
        w_report = 1'b1;
        if (CONTINUOUS != 0) begin
          w_clr       = 1'b1;
          w_state_nxt = S_MEASURE;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Extra MSB keeps both bounds away from the 0 / all-ones extremes.
  assign w_lo_ok    = ({1'b1, r_ecnt} >= {1'b1, MINV});
  assign w_hi_ok    = ({1'b0, r_ecnt} <= {1'b0, MAXV});
  assign w_in_range = w_lo_ok & w_hi_ok & ~w_loss;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_gate  <= '0;
      r_ecnt  <= '0;
      r_count <= '0;
      r_valid <= 1'b0;
      r_inr   <= 1'b0;
    end else begin
      r_valid <= w_report;
      if (w_clr) begin
        r_gate <= '0;
        r_ecnt <= '0;
      end else if (w_cnt_en) begin
        r_gate <= r_gate + 1'b1;
        if (w_edge && r_ecnt != {COUNT_W{1'b1}}) r_ecnt <= r_ecnt + 1'b1;
      end
      if (w_report) begin
        r_count <= r_ecnt;
        r_inr   <= w_in_range;
      end
    end
  end

`ifdef CLK_FREQ_METER_LOSS_DETECT_EN
  localparam int WW = $clog2(LOSS_TIMEOUT + 1);
  localparam logic [WW-1:0] WLIM = WW'(LOSS_TIMEOUT);

  logic [WW-1:0] r_wd;
  logic [WW-1:0] w_wd_nxt;
  logic          r_loss;

  always_comb begin
    w_wd_nxt = r_wd;
    if (w_edge)            w_wd_nxt = '0;
    else if (r_wd != WLIM) w_wd_nxt = r_wd + 1'b1;
  end

  // Set as the watchdog hits the limit; clear one cycle after it restarts.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wd   <= '0;
      r_loss <= 1'b0;
    end else begin
      r_wd <= w_wd_nxt;
      if (w_wd_nxt == WLIM) r_loss <= 1'b1;
      else if (r_wd == '0)  r_loss <= 1'b0;
    end
  end

  assign w_loss = r_loss;
`else
  assign w_loss = 1'b0;
`endif

  assign busy          = (r_state != S_IDLE);
  assign count         = r_count;
  assign count_valid   = r_valid;
  assign in_range      = r_inr;
  assign loss_of_clock = w_loss;

endmodule

// File: tb/tb_clk_freq_meter.sv
// tb_clk_freq_meter: table-driven and randomized checks of clk_freq_meter
// against a sample-history edge-count model.
module tb_clk_freq_meter;

  localparam int G = 100;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic meas_in = 1'b0;

  logic        busy, cv, ir, lol;
  logic [15:0] cnt;
  logic        busy_s, cv_s, ir_s, lol_s;
  logic [3:0]  cnt_s;
  logic        busy_c, cv_c, ir_c, lol_c;
  logic [15:0] cnt_c;

  clk_freq_meter #(
    .GATE_CYCLES(G), .COUNT_W(16), .MIN_COUNT(8), .MAX_COUNT(12),
    .CONTINUOUS(0), .LOSS_TIMEOUT(50)
  ) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .meas_in(meas_in),
    .busy(busy), .count(cnt), .count_valid(cv), .in_range(ir),
    .loss_of_clock(lol)
  );

  clk_freq_meter #(
    .GATE_CYCLES(G), .COUNT_W(4), .MIN_COUNT(8), .MAX_COUNT(12),
    .CONTINUOUS(0), .LOSS_TIMEOUT(50)
  ) dut_s (
    .clock(clock), .reset_n(reset_n), .start(start), .meas_in(meas_in),
    .busy(busy_s), .count(cnt_s), .count_valid(cv_s), .in_range(ir_s),
    .loss_of_clock(lol_s)
  );

  clk_freq_meter #(
    .GATE_CYCLES(G), .COUNT_W(16), .MIN_COUNT(8), .MAX_COUNT(12),
    .CONTINUOUS(1), .LOSS_TIMEOUT(50)
  ) dut_c (
    .clock(clock), .reset_n(reset_n), .start(start), .meas_in(meas_in),
    .busy(busy_c), .count(cnt_c), .count_valid(cv_c), .in_range(ir_c),
    .loss_of_clock(lol_c)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  bit hist [0:16383];

  bit gen_on = 1'b0;
  bit gen_rnd = 1'b0;
  int hi_len = 5;
  int lo_len = 5;
  int ph = 0;

  int c_t0 = 0;
  int n_cv = 0;

  typedef struct {
    int half;
    bit on;
    bit rnd;
    int e_cnt;
    int e_sat;
    int e_inr;
    int e_inr_s;
  } vec_t;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Edges the synchroniser would see: sample history, zero while in reset.
  function automatic int model(input int t0, input int w);
    int c = 0;
    int lim = (1 << w) - 1;
    for (int j = 1; j <= G; j++)
      if (hist[t0 + j - 2] && !hist[t0 + j - 3]) c++;
    if (c > lim) c = lim;
    return c;
  endfunction

  function automatic int inr(input int c);
    return (c >= 8 && c <= 12) ? 1 : 0;
  endfunction

  initial forever begin
    @(posedge clock);
    cyc++;
    if (cyc < 16384) hist[cyc] = reset_n ? meas_in : 1'b0;
  end

  initial forever begin
    @(negedge clock);
    if (!gen_on) begin
      meas_in = 1'b0;
      ph = 0;
    end else if (ph <= 1) begin
      meas_in = ~meas_in;
      if (gen_rnd) ph = int'($urandom_range(7, 2));
      else ph = meas_in ? hi_len : lo_len;
    end else begin
      ph--;
    end
  end

  initial forever begin
    @(negedge clock);
    if (reset_n && cv_c) begin
      int e;
      n_cv++;
      chk("cont_spacing", cyc, c_t0 + G + 1);
      e = model(c_t0, 16);
      chk("cont_count", int'(cnt_c), e);
      chk("cont_in_range", int'(ir_c), inr(e));
      c_t0 = cyc;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1);
  end

  task automatic run_win(input int e_cnt, input int e_sat, input int e_inr,
                         input int e_inr_s, input string tag);
    int t0, nb, nv, fv, cm, im, nv_s, fv_s, cs, is_;
    int x_cnt, x_sat, x_inr, x_inr_s;
    nb = 0; nv = 0; fv = -1; cm = 0; im = 0;
    nv_s = 0; fv_s = -1; cs = 0; is_ = 0;
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    t0 = cyc;
    for (int o = 0; o <= G + 2; o++) begin
      if (o > 0) @(negedge clock);
      if (busy) nb++;
      if (cv) begin
        nv++;
        if (fv < 0) begin fv = o; cm = int'(cnt); im = int'(ir); end
      end
      if (cv_s) begin
        nv_s++;
        if (fv_s < 0) begin fv_s = o; cs = int'(cnt_s); is_ = int'(ir_s); end
      end
    end
    x_cnt   = (e_cnt < 0) ? model(t0, 16) : e_cnt;
    x_sat   = (e_sat < 0) ? model(t0, 4) : e_sat;
    x_inr   = (e_inr < 0) ? inr(x_cnt) : e_inr;
    x_inr_s = (e_inr_s < 0) ? inr(x_sat) : e_inr_s;
    chk({tag, "_busy_cycles"}, nb, G + 1);
    chk({tag, "_valid_at"}, fv, G + 1);
    chk({tag, "_valid_pulses"}, nv, 1);
    chk({tag, "_count"}, cm, x_cnt);
    chk({tag, "_in_range"}, im, x_inr);
    chk({tag, "_sat_valid_at"}, fv_s, G + 1);
    chk({tag, "_sat_pulses"}, nv_s, 1);
    chk({tag, "_sat_count"}, cs, x_sat);
    chk({tag, "_sat_in_range"}, is_, x_inr_s);
  endtask

  initial begin
    vec_t tbl [10];
    int nv;
    tbl[0] = '{5, 1'b1, 1'b0, 10, 10, 1, 1};
    tbl[1] = '{5, 1'b0, 1'b0, 0, 0, 0, 0};
    tbl[2] = '{2, 1'b1, 1'b0, 25, 15, 0, 0};
    tbl[3] = '{6, 1'b1, 1'b0, -1, -1, -1, -1};
    tbl[4] = '{3, 1'b1, 1'b0, -1, -1, -1, -1};
    for (int i = 5; i < 10; i++) tbl[i] = '{0, 1'b1, 1'b1, -1, -1, -1, -1};

    repeat (4) @(negedge clock);
    chk("rst_busy", int'(busy), 0);
    chk("rst_count", int'(cnt), 0);
    chk("rst_valid", int'(cv), 0);
    chk("rst_in_range", int'(ir), 0);
    chk("rst_loss", int'(lol), 0);
    reset_n = 1'b1;
    c_t0 = cyc + 1;

    for (int i = 0; i < 10; i++) begin
      gen_on  = tbl[i].on;
      gen_rnd = tbl[i].rnd;
      hi_len  = tbl[i].half;
      lo_len  = tbl[i].half;
      repeat (20) @(negedge clock);
      run_win(tbl[i].e_cnt, tbl[i].e_sat, tbl[i].e_inr, tbl[i].e_inr_s,
              $sformatf("v%0d", i));
    end

    gen_on = 1'b1; gen_rnd = 1'b0; hi_len = 5; lo_len = 5;
    repeat (20) @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (50) @(negedge clock);
    reset_n = 1'b0;
    #1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_count", int'(cnt), 0);
    chk("midrst_valid", int'(cv), 0);
    chk("midrst_in_range", int'(ir), 0);
    chk("midrst_cont_busy", int'(busy_c), 0);
    chk("midrst_sat_count", int'(cnt_s), 0);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    c_t0 = cyc + 1;
    nv = 0;
    repeat (120) begin
      @(negedge clock);
      if (cv) nv++;
    end
    chk("midrst_no_valid", nv, 0);
    run_win(10, 10, 1, 1, "post_rst");

`ifdef CLK_FREQ_METER_LOSS_DETECT_EN
    begin
      int p, lr, lc, rs;
      gen_on = 1'b0;
      repeat (3) @(negedge clock);
      p = -1;
      for (int k = cyc; k > 3 && p < 0; k--)
        if (hist[k] && !hist[k - 1]) p = k;
      lr = -1;
      for (int k = 0; k < 200 && lr < 0; k++) begin
        @(negedge clock);
        if (lol) lr = cyc;
      end
      chk("loss_rise_cycle", lr, p + 52);
      chk("loss_sat_dut", int'(lol_s), 1);
      chk("loss_cont_dut", int'(lol_c), 1);
      run_win(0, 0, 0, 0, "loss_win");
      chk("loss_held", int'(lol), 1);
      gen_on = 1'b1; gen_rnd = 1'b0; hi_len = 5; lo_len = 5;
      rs = cyc;
      lc = -1;
      for (int k = 0; k < 40 && lc < 0; k++) begin
        @(negedge clock);
        if (!lol) lc = cyc;
      end
      p = -1;
      for (int k = rs + 1; k <= cyc && p < 0; k++)
        if (hist[k]) p = k;
      chk("loss_clear_cycle", lc, p + 3);
      repeat (20) @(negedge clock);
      run_win(10, 10, 1, 1, "loss_recover");
    end
`else
    gen_on = 1'b0;
    repeat (80) @(negedge clock);
    chk("no_loss_flag", int'(lol), 0);
    chk("no_loss_flag_sat", int'(lol_s), 0);
    chk("no_loss_flag_cont", int'(lol_c), 0);
`endif

    chk("cont_reports_seen", (n_cv >= 10) ? 1 : 0, 1);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
